fa_nbit_seq: RTL and testbench
==============================

# fa_nbit_seq

Multi-cycle, parametrised ripple adder/subtractor that generalises the 4-bit full adder to WIDTH bits. It processes CHUNK bits per clock with a registered carry, trading latency for a short carry chain. It sits between operand registers and result consumers, using a start/busy/done handshake, and adds a subtract mode and a signed-overflow flag that the combinational 4-bit adder does not have.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of CHUNK.
- CHUNK, 4, bits added per clock; 1 ≤ CHUNK ≤ WIDTH.
- Derived: N = WIDTH/CHUNK, the number of chunk cycles.
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; accepted only when busy=0.
- sub  in  1  0: a+b+ci; 1: a−b (computed as a + ~b + 1; ci ignored).
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- ci  in  1  carry-in (add mode only).
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; so/co/ovf are valid and newly updated.
- so  out  WIDTH  sum/difference, modulo 2^WIDTH.
- co  out  1  carry out of the MSB; in sub mode, 1 = no borrow (a ≥ b unsigned).
- ovf  out  1  signed overflow = carry into MSB XOR carry out of MSB.

## Operation
- States:
  - IDLE: start=1 → RUN, and the inputs are captured.
  - RUN: chunk index k runs 0..N−1; at k=N−1 → DONE.
  - DONE: always → IDLE after one cycle; start=1 in DONE → RUN, and the inputs are captured (back-to-back).
- Capture: a, b (inverted when sub=1), sub, and initial carry (ci, or 1 when sub=1) are latched. Later input changes have no effect on the operation in flight.
- Each RUN cycle adds chunk k of the latched A and B with the registered carry. The CHUNK-bit result goes into an internal accumulator; the carry register updates.
- Outputs:
  - so/co/ovf are written only at the RUN→DONE edge and otherwise hold the last result.
  - Partial results never appear on so.
  - ovf uses the carry into bit WIDTH−1 (internal) and the final carry.
- start while busy=1: ignored; no queuing.
- Arithmetic is unsigned modulo 2^WIDTH. ci=1 with a=b=all-ones gives so=all-ones, co=1.
- Reset (any time, including mid-RUN): state IDLE, busy=0, done=0, so=0, co=0, ovf=0, k=0, carry=0. The aborted operation produces no done.

## Timing
- Cycle 0 = the cycle with start=1 sampled in IDLE/DONE.
- busy=1 in cycles 1..N; done=1 only in cycle N+1, with busy=0 in that cycle.
- Latency: start to done = N+1 cycles.
- Throughput with back-to-back starts: one result per N+1 cycles.
- CHUNK=WIDTH gives N=1: busy for 1 cycle, done in cycle 2.
- done is registered; all outputs are registered with no combinational input→output path.
- Reset deassertion: start is honoured from the first clock edge after rst falls.

## Test plan
WIDTH=16, CHUNK=4 (N=4) unless noted.
- Reset: assert rst mid-clock → busy=0, done=0, so=0x0000, co=0, ovf=0 immediately (asynchronous).
- a=2, b=5, ci=0, sub=0, start in cycle 0 → busy in cycles 1–4, done in cycle 5, so=0x0007, co=0, ovf=0. a/b changed to 20/3 in cycle 1 → result is unaffected.
- Add boundaries:
  - a=0xFFFF, b=0x0001, ci=0 → so=0x0000, co=1, ovf=0.
  - a=0x7FFF, b=0x0001 → so=0x8000, co=0, ovf=1.
  - a=0xFFFF, b=0xFFFF, ci=1 → so=0xFFFF, co=1.
- Subtract:
  - a=3, b=5, sub=1 → so=0xFFFE, co=0, ovf=0.
  - a=0x8000, b=0x0001 → so=0x7FFF, co=1, ovf=1.
  - a=b=0x1234 → so=0, co=1.
- Handshake:
  - start pulsed in cycles 2–3 while busy → ignored, single done in cycle 5.
  - start held high in the done cycle → next operation accepted, next done 5 cycles later.
  - Repeat the back-to-back case with CHUNK=16 (N=1) → done every 2 cycles.
- Reset in cycle 3 of RUN → no done pulse; so/co/ovf=0. A new start after release completes normally with the correct result.

Source files
------------

// File: rtl/fa_nbit_seq.sv
// Multi-cycle WIDTH-bit adder/subtractor: adds CHUNK bits per clock through a
// registered carry, with a start/busy/done handshake and signed-overflow flag.
module fa_nbit_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] so,
  output logic             co,
  output logic             ovf
);

  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] so_q, so_d;
  logic             co_q, co_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  int               base;
  logic [CHUNK-1:0] a_c, b_c;
  logic [CHUNK:0]   sum_c;
  logic             c_msb;
  logic             capture;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    so_d    = so_q;
    co_d    = co_q;
    ovf_d   = ovf_q;

    base  = int'(k_q) * CHUNK;
    a_c   = a_q[base +: CHUNK];
    b_c   = b_q[base +: CHUNK];
    sum_c = {1'b0, a_c} + {1'b0, b_c} + {{CHUNK{1'b0}}, carry_q};
    // Carry into the chunk MSB, recovered from its sum bit; meaningful on the last chunk.
    c_msb = sum_c[CHUNK-1] ^ a_c[CHUNK-1] ^ b_c[CHUNK-1];

    capture = start && (state_q != S_RUN);

    case (state_q)
      S_RUN: begin
        acc_d[base +: CHUNK] = sum_c[CHUNK-1:0];
        carry_d              = sum_c[CHUNK];
        if (k_q == K_LAST) begin
          state_d = S_DONE;
          k_d     = '0;
          so_d    = acc_d;
          co_d    = sum_c[CHUNK];
          ovf_d   = c_msb ^ sum_c[CHUNK];
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Subtraction is a + ~b + 1, so only the capture path knows about sub.
    if (capture) begin
      state_d = S_RUN;
      k_d     = '0;
      a_d     = a;
      b_d     = sub ? ~b : b;
      carry_d = sub ? 1'b1 : ci;
    end

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      carry_q <= 1'b0;
      so_q    <= '0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      carry_q <= carry_d;
      so_q    <= so_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    a_q   <= a_d;
    b_q   <= b_d;
    acc_q <= acc_d;
  end

  assign busy = busy_q;
  assign done = done_q;
  assign so   = so_q;
  assign co   = co_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_fa_nbit_seq.sv
// Randomised and directed bench for fa_nbit_seq against an integer-arithmetic model.
module tb_fa_nbit_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, sub, ci, busy, done, co, ovf;
  logic [15:0] a, b, so;
  logic        start1, sub1, ci1, busy1, done1, co1, ovf1;
  logic [15:0] a1, b1, so1;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  fa_nbit_seq #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .ci(ci),
    .busy(busy), .done(done), .so(so), .co(co), .ovf(ovf)
  );

  fa_nbit_seq #(.WIDTH(16), .CHUNK(16)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .sub(sub1), .a(a1), .b(b1), .ci(ci1),
    .busy(busy1), .done(done1), .so(so1), .co(co1), .ovf(ovf1)
  );

  task automatic model(input logic [15:0] ma, mb, input logic mci, msub,
                       output logic [15:0] eso, output logic eco, eovf);
    logic [15:0] be;
    logic        c;
    logic [16:0] t;
    int          s;
    be   = msub ? ~mb : mb;
    c    = msub ? 1'b1 : mci;
    t    = {1'b0, ma} + {1'b0, be} + {16'd0, c};
    eso  = t[15:0];
    eco  = t[16];
    s    = int'($signed(ma)) + int'($signed(be)) + int'(c);
    eovf = (s > 32767) || (s < -32768);
  endtask

  // Cycle 0 = negedge where start is driven; cycle c outputs are sampled at the c-th following negedge.
  task automatic do_op(input logic [15:0] ia, ib, input logic ici, isub,
                       output int lat, output bit busy_ok);
    lat     = -1;
    busy_ok = 1'b1;
    @(negedge clk);
    a = ia; b = ib; ci = ici; sub = isub; start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start = 1'b0;
        a = 16'($urandom); b = 16'($urandom); ci = 1'($urandom); sub = 1'($urandom);
      end
      if (done === 1'b1) begin
        if (busy !== 1'b0) busy_ok = 1'b0;
        lat = c;
        break;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 0; sub = 0; ci = 0; a = 0; b = 0;
    start1 = 0; sub1 = 0; ci1 = 0; a1 = 0; b1 = 0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, done, so, co, ovf} !== 19'd0)
      $display("FAIL reset_state: got busy=%b done=%b so=%h co=%b ovf=%b, want all 0", busy, done, so, co, ovf);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_basic;
    int lat; bit bok;
    do_op(16'd2, 16'd5, 1'b0, 1'b0, lat, bok);
    n_checks++;
    if (lat !== 5) $display("FAIL basic_latency: got %0d want 5", lat); else n_pass++;
    n_checks++;
    if (bok !== 1'b1) $display("FAIL basic_busy: busy pattern wrong (got %b want 1)", bok); else n_pass++;
    n_checks++;
    if ({so, co, ovf} !== {16'h0007, 1'b0, 1'b0})
      $display("FAIL basic_result: got so=%h co=%b ovf=%b want so=0007 co=0 ovf=0", so, co, ovf);
    else n_pass++;
  endtask

  task automatic test_directed;
    logic [15:0] va[6] = '{16'hFFFF, 16'h7FFF, 16'hFFFF, 16'd3, 16'h8000, 16'h1234};
    logic [15:0] vb[6] = '{16'h0001, 16'h0001, 16'hFFFF, 16'd5, 16'h0001, 16'h1234};
    logic        vc[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic        vs[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [15:0] eso; logic eco, eovf; int lat; bit bok;
    for (int i = 0; i < 6; i++) begin
      model(va[i], vb[i], vc[i], vs[i], eso, eco, eovf);
      do_op(va[i], vb[i], vc[i], vs[i], lat, bok);
      n_checks++;
      if (lat !== 5 || bok !== 1'b1)
        $display("FAIL directed%0d_timing: got lat=%0d busy_ok=%b want lat=5 busy_ok=1", i, lat, bok);
      else n_pass++;
      n_checks++;
      if ({so, co, ovf} !== {eso, eco, eovf})
        $display("FAIL directed%0d_result: got so=%h co=%b ovf=%b want so=%h co=%b ovf=%b",
                 i, so, co, ovf, eso, eco, eovf);
      else n_pass++;
    end
  endtask

  task automatic test_random;
    logic [15:0] ra, rb, eso; logic rc, rs, eco, eovf; int lat; bit bok;
    for (int i = 0; i < 30; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      if (i % 7 == 0) ra = {1'b0, 15'h7FFF} ^ {15'd0, rc};
      model(ra, rb, rc, rs, eso, eco, eovf);
      do_op(ra, rb, rc, rs, lat, bok);
      n_checks++;
      if (lat !== 5 || bok !== 1'b1 || {so, co, ovf} !== {eso, eco, eovf})
        $display("FAIL random%0d: a=%h b=%h ci=%b sub=%b got lat=%0d so=%h co=%b ovf=%b want lat=5 so=%h co=%b ovf=%b",
                 i, ra, rb, rc, rs, lat, so, co, ovf, eso, eco, eovf);
      else n_pass++;
    end
  endtask

  task automatic test_start_ignored;
    int dones = 0; int first = -1;
    @(negedge clk);
    a = 16'd100; b = 16'd23; ci = 0; sub = 0; start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        dones++;
        if (first < 0) first = c;
      end
      if (c == 1) begin a = 16'($urandom); b = 16'($urandom); end
      start = (c == 2 || c == 3);
    end
    start = 1'b0;
    n_checks++;
    if (dones !== 1 || first !== 5)
      $display("FAIL start_ignored_done: got %0d dones first at %0d, want 1 at 5", dones, first);
    else n_pass++;
    n_checks++;
    if (so !== 16'd123) $display("FAIL start_ignored_result: got so=%h want 007b", so); else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [15:0] ea[3], eb[3], eso; logic es[3], eco, eovf; bit pat_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin ea[i] = 16'($urandom); eb[i] = 16'($urandom); es[i] = 1'($urandom); end
    for (int c = 0; c <= 15; c++) begin
      @(negedge clk);
      if (c > 0 && done !== ((c % 5) == 0)) pat_ok = 1'b0;
      if (c > 0 && (c % 5) == 0) begin
        model(ea[c/5-1], eb[c/5-1], 1'b0, es[c/5-1], eso, eco, eovf);
        n_checks++;
        if ({so, co, ovf} !== {eso, eco, eovf})
          $display("FAIL b2b_result%0d: got so=%h co=%b ovf=%b want so=%h co=%b ovf=%b",
                   c/5-1, so, co, ovf, eso, eco, eovf);
        else n_pass++;
      end
      if ((c % 5) == 0 && c < 15) begin
        a = ea[c/5]; b = eb[c/5]; sub = es[c/5]; ci = 1'b0;
      end else begin
        a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom); ci = 1'($urandom);
      end
      start = (c < 15);
    end
    start = 1'b0;
    n_checks++;
    if (pat_ok !== 1'b1) $display("FAIL b2b_done_pattern: got ok=%b want done every 5 cycles", pat_ok); else n_pass++;
  endtask

  task automatic test_back_to_back_n1;
    logic [15:0] ea[4], eb[4], eso; logic eco, eovf; bit pat_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin ea[i] = 16'($urandom); eb[i] = 16'($urandom); end
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      if (c > 0 && (done1 !== ((c % 2) == 0) || busy1 !== ((c % 2) == 1))) pat_ok = 1'b0;
      if (c > 0 && (c % 2) == 0) begin
        model(ea[c/2-1], eb[c/2-1], 1'b1, 1'b0, eso, eco, eovf);
        n_checks++;
        if ({so1, co1, ovf1} !== {eso, eco, eovf})
          $display("FAIL n1_result%0d: got so=%h co=%b ovf=%b want so=%h co=%b ovf=%b",
                   c/2-1, so1, co1, ovf1, eso, eco, eovf);
        else n_pass++;
      end
      if ((c % 2) == 0 && c < 8) begin
        a1 = ea[c/2]; b1 = eb[c/2]; ci1 = 1'b1; sub1 = 1'b0;
      end else begin
        a1 = 16'($urandom); b1 = 16'($urandom); ci1 = 1'($urandom); sub1 = 1'($urandom);
      end
      start1 = (c < 8);
    end
    start1 = 1'b0;
    n_checks++;
    if (pat_ok !== 1'b1) $display("FAIL n1_done_pattern: got ok=%b want done every 2 cycles", pat_ok); else n_pass++;
  endtask

  task automatic test_reset_mid_run;
    bit saw_done = 1'b0; int lat; bit bok; logic [15:0] eso; logic eco, eovf;
    @(negedge clk);
    a = 16'h4321; b = 16'h1111; ci = 0; sub = 0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, so, co, ovf} !== 19'd0)
      $display("FAIL async_reset: got busy=%b done=%b so=%h co=%b ovf=%b want all 0", busy, done, so, co, ovf);
    else n_pass++;
    @(negedge clk); rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done !== 1'b0 || {so, co, ovf} !== 18'd0)
      $display("FAIL aborted_op: got done_seen=%b so=%h co=%b ovf=%b want 0", saw_done, so, co, ovf);
    else n_pass++;
    model(16'h8000, 16'h8000, 1'b0, 1'b0, eso, eco, eovf);
    do_op(16'h8000, 16'h8000, 1'b0, 1'b0, lat, bok);
    n_checks++;
    if (lat !== 5 || {so, co, ovf} !== {eso, eco, eovf})
      $display("FAIL after_reset_op: got lat=%0d so=%h co=%b ovf=%b want lat=5 so=%h co=%b ovf=%b",
               lat, so, co, ovf, eso, eco, eovf);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_directed();
    test_random();
    test_start_ignored();
    test_back_to_back();
    test_back_to_back_n1();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d checks", n_pass, n_checks);
    $fatal(1);
  end

endmodule
